// File: rtl/axi_burst_reader_pkg.sv
// axi_burst_reader_pkg: shared AXI constants and reader FSM states
package axi_burst_reader_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_4K_BYTES   = 4096;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;
endpackage

// File: rtl/axi_burst_reader_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO, head word visible on pop_data while !empty
module sync_fifo_fwft #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    assign full     = count_q == CW'(DEPTH);
    assign empty    = count_q == '0;
    assign count    = count_q;
    assign pop_data = mem[rd_q];
    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= push_data;
    end
endmodule

// File: rtl/axi_burst_reader.sv
// axi_burst_reader: AXI4 read master streaming a contiguous word block, 4 KB-safe INCR bursts,
// with FIFO credit accounting so rready can stay high.
module axi_burst_reader
    import axi_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int AXI_ID        = 0,
    parameter int LEN_WIDTH     = 20,
    parameter int MAX_BURST_LEN = 64,
    parameter int FIFO_DEPTH    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int PW    = $clog2(FIFO_DEPTH) + 1;

    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, araddr_q, araddr_d, cmd_aligned;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d, total_q, total_d, rcnt_q, rcnt_d;
    logic [PW-1:0] pending_q, pending_d, fifo_count;
    logic [8:0] blen_q, blen_d, next_blen;
    logic arvalid_q, arvalid_d, cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic done_q, done_d, err_q, err_d, rready_q;
    logic push, pop, full, empty, ar_fire, credit_ok, unused_ok;
    logic [DATA_WIDTH:0] pop_data;

    function automatic logic [8:0] calc_blen(input logic [11:0] off, input logic [LEN_WIDTH-1:0] rem);
        int room, n;
        room = (AXI_4K_BYTES - int'(off)) / BYTES;
        n = (int'(rem) < MAX_BURST_LEN) ? int'(rem) : MAX_BURST_LEN;
        return 9'((n < room) ? n : room);
    endfunction

    assign cmd_aligned = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign next_blen   = calc_blen(addr_q[11:0], remaining_q);
    assign ar_fire     = arvalid_q & m_axi_arready;
    assign credit_ok   = int'(FIFO_DEPTH) - int'(fifo_count) - int'(pending_q) >= int'(next_blen);
    assign push        = m_axi_rvalid & rready_q;
    assign pop         = ~empty & out_ready;
    assign unused_ok   = ^{m_axi_rid, m_axi_rlast, full};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        total_d     = total_q;
        araddr_d    = araddr_q;
        blen_d      = blen_q;
        arvalid_d   = arvalid_q;
        done_d      = 1'b0;
        err_d       = err_q | (push & (m_axi_rresp != AXI_RESP_OKAY));
        rcnt_d      = rcnt_q + LEN_WIDTH'(push);
        pending_d   = pending_q + (ar_fire ? PW'(blen_q) : PW'(0)) - PW'(push);
        case (state_q)
            ST_IDLE: if (cmd_valid && cmd_ready_q) begin
                addr_d      = cmd_aligned;
                remaining_d = cmd_beats;
                total_d     = cmd_beats;
                rcnt_d      = '0;
                err_d       = 1'b0;
                done_d      = cmd_beats == '0;
                // Previous command fully drained, so the FIFO is empty and the first burst needs no credit check
                if (cmd_beats != '0) begin
                    state_d   = ST_ISSUE;
                    araddr_d  = cmd_aligned;
                    blen_d    = calc_blen(cmd_aligned[11:0], cmd_beats);
                    arvalid_d = 1'b1;
                end
            end
            ST_ISSUE: if (ar_fire) begin
                arvalid_d   = 1'b0;
                addr_d      = addr_q + (ADDR_WIDTH'(blen_q) << SIZE);
                remaining_d = remaining_q - LEN_WIDTH'(blen_q);
                if (remaining_d == '0) state_d = ST_DRAIN;
            end else if (!arvalid_q && credit_ok) begin
                arvalid_d = 1'b1;
                araddr_d  = addr_q;
                blen_d    = next_blen;
            end
            ST_DRAIN: if (pop && out_last) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d      = state_d != ST_IDLE;
        cmd_ready_d = state_d == ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            total_q     <= '0;
            rcnt_q      <= '0;
            pending_q   <= '0;
            araddr_q    <= '0;
            blen_q      <= '0;
            arvalid_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            total_q     <= total_d;
            rcnt_q      <= rcnt_d;
            pending_q   <= pending_d;
            araddr_q    <= araddr_d;
            blen_q      <= blen_d;
            arvalid_q   <= arvalid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rready_q    <= 1'b1;
        end
    end

    // Word carries its own last flag so the stream side needs no counter
    sync_fifo_fwft #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({rcnt_q == total_q - LEN_WIDTH'(1), m_axi_rdata}),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(blen_q - 9'd1);
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign out_data      = pop_data[DATA_WIDTH-1:0];
    assign out_last      = ~empty & pop_data[DATA_WIDTH];
    assign out_valid     = ~empty;
endmodule

// File: tb/tb_axi_burst_reader.sv
// tb_axi_burst_reader: random AXI RAM slave plus scoreboard against a burst/word reference model.
module tb_axi_burst_reader;
    localparam int DW = 512;
    localparam int LW = 20;
    localparam int DEPTH = 128;

    typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
    typedef struct {logic [DW-1:0] data; logic last;} out_t;
    typedef struct {logic [31:0] addr; int n;} burst_t;

    logic clk = 0, rst = 1;
    logic cmd_valid = 0, cmd_ready;
    logic [31:0] cmd_addr = 0;
    logic [LW-1:0] cmd_beats = 0;
    logic busy, done, err;
    logic [7:0] arid, arlen;
    logic [31:0] araddr;
    logic [2:0] arsize, arprot;
    logic [1:0] arburst, rresp = 0;
    logic arlock, arvalid, arready = 0;
    logic [3:0] arcache;
    logic [7:0] rid = 0;
    logic [DW-1:0] rdata = 0, out_data;
    logic rlast = 0, rvalid = 0, rready, out_last, out_valid, out_ready = 0;

    int n_pass = 0, n_total = 0;
    ar_t exp_ar[$];
    out_t exp_out[$];
    int outstanding = 0, occ = 0, done_cnt = 0, ar_cnt = 0, inj_idx = -1;
    logic hold = 0;

    axi_burst_reader dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_beats(cmd_beats), .busy(busy), .done(done), .err(err), .m_axi_arid(arid),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready), .out_data(out_data),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // AXI RAM: word at byte address a holds a/64; bursts answered in order with random gaps
    initial begin
        burst_t bursts[$];
        logic s_rst, s_ar, s_r, s_acc;
        logic [31:0] s_addr, a;
        logic [7:0] s_len;
        int beat = 0, rcount = 0;
        forever begin
            @(negedge clk);
            s_rst = rst; s_ar = arvalid && arready; s_addr = araddr; s_len = arlen;
            s_r = rvalid && rready; s_acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            if (s_rst) begin
                bursts.delete(); beat = 0; rvalid = 0; arready = 0;
                continue;
            end
            if (s_acc) rcount = 0;
            if (s_ar) bursts.push_back('{s_addr, int'(s_len) + 1});
            if (s_r) begin
                beat++; rcount++;
                if (beat == bursts[0].n) begin
                    void'(bursts.pop_front());
                    beat = 0;
                end
            end
            arready = $urandom_range(0, 9) < 6;
            if (bursts.size() > 0 && $urandom_range(0, 9) < 7) begin
                a = bursts[0].addr + 32'(beat) * 32'd64;
                rvalid = 1; rdata = DW'(a >> 6); rlast = beat == bursts[0].n - 1;
                rresp = (rcount == inj_idx) ? 2'b10 : 2'b00;
            end else rvalid = 0;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops expectations whenever the DUT presents an AR or an output word
    initial begin
        logic prev_wait = 0, prev_lastfire = 0;
        logic [31:0] p_addr;
        logic [7:0] p_len;
        ar_t e;
        out_t o;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_ar.delete(); exp_out.delete();
                outstanding = 0; occ = 0; prev_wait = 0; prev_lastfire = 0;
                continue;
            end
            chk("out_valid_fwft", out_valid, occ > 0);
            if (busy) chk("rready_high", rready, 1);
            if (prev_wait) chk("ar_stable", {arvalid, araddr, arlen}, {1'b1, p_addr, p_len});
            if (prev_lastfire) chk("done_after_last", done, 1);
            if (done) done_cnt++;
            if (arvalid && arready) begin
                ar_cnt++;
                if (exp_ar.size() == 0) chk("unexpected_ar", 1, 0);
                else begin
                    e = exp_ar.pop_front();
                    chk("ar_addr", araddr, e.addr);
                    chk("ar_len", arlen, e.len);
                    chk("ar_fixed", {arsize, arburst, arcache, arid}, {3'd6, 2'b01, 4'b0011, 8'd0});
                end
                outstanding += int'(arlen) + 1;
                chk("credit_bound", outstanding <= DEPTH, 1);
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) chk("unexpected_word", 1, 0);
                else begin
                    o = exp_out.pop_front();
                    chk("out_data", out_data, o.data);
                    chk("out_last", out_last, o.last);
                end
                outstanding--; occ--;
            end
            if (rvalid && rready) occ++;
            prev_wait = arvalid && !arready; p_addr = araddr; p_len = arlen;
            prev_lastfire = out_valid && out_ready && out_last;
        end
    end

    task automatic start_cmd(input logic [31:0] addr, input int beats);
        logic [31:0] a, wa;
        int rem, n, room, t;
        done_cnt = 0; ar_cnt = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_addr = addr; cmd_beats = LW'(beats);
        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        a = addr & ~32'h3F;
        for (int k = 0; k < beats; k++) begin
            wa = a + 32'(k) * 32'd64;
            exp_out.push_back('{DW'(wa >> 6), k == beats - 1});
        end
        rem = beats;
        while (rem > 0) begin
            room = (4096 - int'(a[11:0])) / 64;
            n = rem < 64 ? rem : 64;
            n = n < room ? n : room;
            exp_ar.push_back('{a, 8'(n - 1)});
            a = a + 32'(n) * 32'd64;
            rem -= n;
        end
        @(posedge clk); #1;
        cmd_valid = 0;
        @(negedge clk);
        chk("arvalid_latency", arvalid, beats != 0);
        if (beats != 0) chk("busy_after_accept", busy, 1);
        else chk("zero_beat_done", done, 1);
    endtask

    task automatic wait_done(input logic exp_err, input string tag);
        int t = 0;
        while (!done && t < 20000) begin @(negedge clk); t++; end
        if (!done) begin
            chk({tag, "_done_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy_at_done"}, busy, 0);
        repeat (2) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_words_left"}, exp_out.size(), 0);
        chk({tag, "_ar_left"}, exp_ar.size(), 0);
        chk({tag, "_idle"}, {busy, cmd_ready}, 2'b01);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_outs"}, {cmd_ready, busy, done, err, arvalid, out_valid, out_last, rready}, 8'd0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1; rst = 0;

        start_cmd(32'h0, 4);          wait_done(0, "small");
        start_cmd(32'h0, 300);        wait_done(0, "multi_burst");
        start_cmd(32'h0FC0, 3);       wait_done(0, "cross_4k");

        hold = 1;
        start_cmd(32'h0, 300);
        repeat (500) @(negedge clk);
        chk("hold_outstanding", outstanding, DEPTH);
        chk("hold_ar_count", ar_cnt, 2);
        hold = 0;
        wait_done(0, "backpressure");

        start_cmd(32'h1234, 0);       wait_done(0, "zero");
        start_cmd(32'h40, 2);         wait_done(0, "after_zero");

        inj_idx = 4;
        start_cmd(32'h100, 8);        wait_done(1, "slverr");
        inj_idx = -1;
        start_cmd(32'h2000, 5);       wait_done(0, "err_cleared");

        start_cmd(32'hFFFF_FF80, 5);  wait_done(0, "addr_wrap");
        for (int i = 0; i < 5; i++) begin
            start_cmd($urandom, int'($urandom_range(1, 150)));
            wait_done(0, "random");
        end

        start_cmd(32'h0, 300);
        t = 0;
        while (ar_cnt < 2 && t < 5000) begin @(negedge clk); t++; end
        chk("rst_second_burst_seen", ar_cnt >= 2, 1);
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        @(posedge clk); #1; rst = 0;
        start_cmd(32'h200, 10);       wait_done(0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
